ps2_uart_tx_queue: RTL and testbench

//  Parametrised keyboard/switch-to-UART sender with a TX FIFO. Filters PS/2 break (F0) and

---
 rtl/ps2_uart_tx_queue.sv | 253 +++++++++++++++++++++++++
 tb/tb_ps2_uart_tx_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_uart_tx_queue.sv
// PS/2 make-code filter, keyboard/manual byte merge into a TX FIFO, and UART drain FSM.
// Optional SENDER_OVF_CNT_EN adds a saturating drop_count output.
module ps2_uart_tx_queue #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int FLAG_MSB = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [7:0]        key_code,
    output logic              make_valid,
    output logic [7:0]        make_code,
    output logic              make_ext,
    input  logic              map_valid,
    input  logic [DATA_W-1:0] map_data,
    input  logic              lang,
    input  logic              man_send,
    input  logic [DATA_W-1:0] man_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
`ifdef SENDER_OVF_CNT_EN
    output logic [7:0]        drop_count,
`endif
    output logic              drop
);

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);

    typedef enum logic [1:0] {F_IDLE, F_BRK, F_EXT, F_EXT_BRK} filt_state_e;
    typedef enum logic [1:0] {T_IDLE, T_GUARD, T_WAIT} tx_state_e;

    filt_state_e filt_q, filt_d;
    tx_state_e   tx_q, tx_d;

    logic              emit_s, emit_ext_s;
    logic              make_valid_q, make_ext_q;
    logic [7:0]        make_code_q;

    logic              kbd_wr_s;
    logic [DATA_W-1:0] kbd_byte_s;
    logic              wr_en_s, lost_s, push_s, pop_s, full_s, empty_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              drop_q, drop_d;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;

    // Filter next state: break sequences are swallowed, E0 marks the next make as extended
    always_comb begin
        filt_d     = filt_q;
        emit_s     = 1'b0;
        emit_ext_s = 1'b0;
        if (key_valid) begin
            case (filt_q)
                F_IDLE: begin
                    if (key_code == 8'hF0) begin
                        filt_d = F_BRK;
                    end else if (key_code == 8'hE0) begin
                        filt_d = F_EXT;
                    end else begin
                        emit_s = 1'b1;
                    end
                end
                F_BRK:     filt_d = F_IDLE;
                F_EXT: begin
                    if (key_code == 8'hF0) begin
                        filt_d = F_EXT_BRK;
                    end else begin
                        emit_s     = 1'b1;
                        emit_ext_s = 1'b1;
                        filt_d     = F_IDLE;
                    end
                end
                F_EXT_BRK: filt_d = F_IDLE;
                default:   filt_d = F_IDLE;
            endcase
        end else begin
            filt_d = filt_q;
        end
    end

    // Filter state and make-code outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q       <= F_IDLE;
            make_valid_q <= 1'b0;
            make_code_q  <= 8'h00;
            make_ext_q   <= 1'b0;
        end else begin
            filt_q       <= filt_d;
            make_valid_q <= emit_s;
            if (emit_s) begin
                make_code_q <= key_code;
                make_ext_q  <= emit_ext_s;
            end
        end
    end

    assign kbd_wr_s   = map_valid && (map_data != '0);
    assign kbd_byte_s = (FLAG_MSB != 0) ? {lang, map_data[DATA_W-2:0]} : map_data;

    // Write arbitration, oldest first: skid, then manual, then keyboard; a third contender is lost
    always_comb begin
        wr_en_s     = 1'b0;
        wr_data_s   = '0;
        skid_vld_d  = 1'b0;
        skid_data_d = skid_data_q;
        lost_s      = 1'b0;
        if (skid_vld_q) begin
            wr_en_s   = 1'b1;
            wr_data_s = skid_data_q;
            if (man_send) begin
                skid_vld_d  = 1'b1;
                skid_data_d = man_data;
                lost_s      = kbd_wr_s;
            end else if (kbd_wr_s) begin
                skid_vld_d  = 1'b1;
                skid_data_d = kbd_byte_s;
            end else begin
                skid_vld_d  = 1'b0;
            end
        end else if (man_send) begin
            wr_en_s   = 1'b1;
            wr_data_s = man_data;
            if (kbd_wr_s) begin
                skid_vld_d  = 1'b1;
                skid_data_d = kbd_byte_s;
            end else begin
                skid_vld_d  = 1'b0;
            end
        end else if (kbd_wr_s) begin
            wr_en_s   = 1'b1;
            wr_data_s = kbd_byte_s;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == '0);
    assign push_s  = wr_en_s && (!full_s || pop_s);
    assign drop_d  = (wr_en_s && full_s && !pop_s) || lost_s;

    // Occupancy next value
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // TX handshake: guard cycle covers the UART's busy-rise latency after tx_start
    always_comb begin
        tx_d  = tx_q;
        pop_s = 1'b0;
        case (tx_q)
            T_IDLE: begin
                if (!empty_s && !tx_busy) begin
                    pop_s = 1'b1;
                    tx_d  = T_GUARD;
                end else begin
                    tx_d  = T_IDLE;
                end
            end
            T_GUARD: tx_d = T_WAIT;
            T_WAIT: begin
                if (!tx_busy) begin
                    tx_d = T_IDLE;
                end else begin
                    tx_d = T_WAIT;
                end
            end
            default: tx_d = T_IDLE;
        endcase
    end

    // FIFO pointers, skid register, TX state and registered strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            drop_q      <= 1'b0;
            tx_q        <= T_IDLE;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                tx_data_q <= mem_q[rd_ptr_q];
            end
            count_q     <= count_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            drop_q      <= drop_d;
            tx_q        <= tx_d;
            tx_start_q  <= pop_s;
        end
    end

    // Storage array; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

`ifdef SENDER_OVF_CNT_EN
    logic [7:0] drop_cnt_q;

    // Saturating count of lost writes
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else if (drop_d && (drop_cnt_q != 8'd255)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    assign make_valid = make_valid_q;
    assign make_code  = make_code_q;
    assign make_ext   = make_ext_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign fifo_count = count_q;
    assign fifo_full  = full_s;
    assign fifo_empty = empty_s;
    assign drop       = drop_q;

endmodule

// File: tb/tb_ps2_uart_tx_queue.sv
// Directed bench for ps2_uart_tx_queue: table-driven filter vectors plus hand-written FIFO/TX sequences.
module tb_ps2_uart_tx_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset;
    logic              key_valid;
    logic [7:0]        key_code;
    logic              make_valid;
    logic [7:0]        make_code;
    logic              make_ext;
    logic              map_valid;
    logic [DATA_W-1:0] map_data;
    logic              lang;
    logic              man_send;
    logic [DATA_W-1:0] man_data;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;
    logic [7:0]        drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

    ps2_uart_tx_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FLAG_MSB(1)) dut (
`ifdef SENDER_OVF_CNT_EN
        .drop_count (drop_count),
`endif
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .make_valid (make_valid),
        .make_code  (make_code),
        .make_ext   (make_ext),
        .map_valid  (map_valid),
        .map_data   (map_data),
        .lang       (lang),
        .man_send   (man_send),
        .man_data   (man_data),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    logic [7:0] txq [$];
    int         drops_seen = 0;
    int         spacing_err = 0;
    int         cyc = 0;
    int         last_start = -100;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_start) begin
            txq.push_back(tx_data);
            if (cyc - last_start < 3) spacing_err <= spacing_err + 1;
            last_start <= cyc;
        end
        if (drop) drops_seen <= drops_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] code;
        logic       exp_mv;
        logic [7:0] exp_code;
        logic       exp_ext;
    } vec_t;

    vec_t vecs [9];
    int   d0;

    initial begin
        vecs[0] = '{8'h1C, 1'b1, 8'h1C, 1'b0};
        vecs[1] = '{8'hF0, 1'b0, 8'h1C, 1'b0};
        vecs[2] = '{8'h1C, 1'b0, 8'h1C, 1'b0};
        vecs[3] = '{8'hE0, 1'b0, 8'h1C, 1'b0};
        vecs[4] = '{8'h75, 1'b1, 8'h75, 1'b1};
        vecs[5] = '{8'hE0, 1'b0, 8'h75, 1'b1};
        vecs[6] = '{8'hF0, 1'b0, 8'h75, 1'b1};
        vecs[7] = '{8'h75, 1'b0, 8'h75, 1'b1};
        vecs[8] = '{8'h1C, 1'b1, 8'h1C, 1'b0};

        reset = 1'b1; key_valid = 1'b0; key_code = 8'h00; map_valid = 1'b0;
        map_data = 8'h00; lang = 1'b0; man_send = 1'b0; man_data = 8'h00; tx_busy = 1'b0;
        #1;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_make_valid", 32'(make_valid), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);

        // Filter vectors
        for (int i = 0; i < 9; i++) begin
            key_valid = 1'b1; key_code = vecs[i].code;
            tick();
            key_valid = 1'b0;
            check($sformatf("flt%0d_valid", i), 32'(make_valid), 32'(vecs[i].exp_mv));
            check($sformatf("flt%0d_code", i), 32'(make_code), 32'(vecs[i].exp_code));
            check($sformatf("flt%0d_ext", i), 32'(make_ext), 32'(vecs[i].exp_ext));
            tick();
            check($sformatf("flt%0d_pulse", i), 32'(make_valid), 32'd0);
        end

        // Latency: write at edge N gives tx_start after edge N+1
        txq.delete();
        man_send = 1'b1; man_data = 8'h5A;
        tick();
        man_send = 1'b0;
        check("lat_no_start_yet", 32'(tx_start), 32'd0);
        check("lat_count1", 32'(fifo_count), 32'd1);
        tick();
        check("lat_start", 32'(tx_start), 32'd1);
        check("lat_data", 32'(tx_data), 32'h5A);
        check("lat_count0", 32'(fifo_count), 32'd0);
        tick();
        check("lat_start_pulse", 32'(tx_start), 32'd0);
        repeat (3) tick();
        map_valid = 1'b1; map_data = 8'h00;
        tick();
        map_valid = 1'b0;
        check("zero_map_count", 32'(fifo_count), 32'd0);
        check("zero_map_drop", 32'(drop), 32'd0);
        tick();
        check("zero_map_no_start", 32'(tx_start), 32'd0);

        // Manual and keyboard same cycle: manual first, keyboard via skid with lang in MSB
        repeat (3) tick();
        txq.delete();
        man_send = 1'b1; man_data = 8'h41; map_valid = 1'b1; map_data = 8'h61; lang = 1'b1;
        tick();
        man_send = 1'b0; map_valid = 1'b0; lang = 1'b0;
        repeat (12) tick();
        check("merge_n", 32'(txq.size()), 32'd2);
        if (txq.size() == 2) begin
            check("merge_b0", 32'(txq[0]), 32'h41);
            check("merge_b1", 32'(txq[1]), 32'hE1);
        end

        // Overflow with busy held, then push-while-popping at full
        tx_busy = 1'b1;
        d0 = drops_seen;
        for (int i = 0; i < DEPTH + 2; i++) begin
            man_send = 1'b1; man_data = 8'(8'h10 + i);
            tick();
        end
        man_send = 1'b0;
        tick();
        check("ovf_count", 32'(fifo_count), 32'(DEPTH));
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_empty", 32'(fifo_empty), 32'd0);
        check("ovf_drops", 32'(drops_seen - d0), 32'd2);
        txq.delete();
        tx_busy = 1'b0; man_send = 1'b1; man_data = 8'hAA;
        tick();
        man_send = 1'b0;
        check("fullpp_count", 32'(fifo_count), 32'(DEPTH));
        check("fullpp_full", 32'(fifo_full), 32'd1);
        check("fullpp_drop", 32'(drop), 32'd0);
        for (int i = 0; i < 300 && !(fifo_empty && txq.size() >= DEPTH + 1); i++) tick();
        repeat (4) tick();
        check("drain_empty", 32'(fifo_empty), 32'd1);
        check("drain_n", 32'(txq.size()), 32'(DEPTH + 1));
        for (int i = 0; i < DEPTH + 1 && i < txq.size(); i++) begin
            check($sformatf("drain_b%0d", i), 32'(txq[i]),
                  (i < DEPTH) ? 32'(8'h10 + i) : 32'hAA);
        end
`ifdef SENDER_OVF_CNT_EN
        check("drop_count", 32'(drop_count), 32'd2);
`endif

        // Reset while waiting on the UART with three bytes queued
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            man_send = 1'b1; man_data = 8'(8'hC0 + i);
            tick();
        end
        man_send = 1'b0;
        tx_busy = 1'b0;
        tick();
        check("rstw_start", 32'(tx_start), 32'd1);
        tx_busy = 1'b1;
        tick();
        tick();
        check("rstw_count3", 32'(fifo_count), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0; tx_busy = 1'b0;
        check("rstw_count0", 32'(fifo_count), 32'd0);
        check("rstw_empty", 32'(fifo_empty), 32'd1);
        check("rstw_tx_start", 32'(tx_start), 32'd0);
        txq.delete();
        repeat (20) tick();
        check("rstw_no_strobes", 32'(txq.size()), 32'd0);
        check("strobe_spacing", 32'(spacing_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
